// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, state encodings and helpers for the writeback mux
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_RD_W   = 4;

  localparam int SRC_ALU   = 0;
  localparam int SRC_RAM   = 1;
  localparam int SRC_TIMER = 2;
  localparam int SRC_HD    = 3;

  typedef logic [1:0] wb_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of a source index; a single source still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/writeback_mux_seq_if.sv
// rtl/writeback_mux_seq_if.sv - request, source and writeback signals of the writeback mux
// Optional WB_TIMEOUT_EN adds timeout_err.
interface writeback_mux_seq_if
  import wb_pkg::*;
#(
  parameter int DATA_W  = WB_DATA_W,
  parameter int NUM_SRC = 4,
  parameter int RD_W    = WB_RD_W
);
  localparam int SEL_W = sel_width(NUM_SRC);

  logic                      req_valid;
  logic [SEL_W-1:0]          req_sel;
  logic [RD_W-1:0]           req_rd;
  logic                      req_ready;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_valid;
  logic                      stall;
  logic                      wb_valid;
  logic [DATA_W-1:0]         wb_data;
  logic [RD_W-1:0]           wb_rd;
  logic                      sel_err;
`ifdef WB_TIMEOUT_EN
  logic                      timeout_err;

  modport master (
    output req_valid, req_sel, req_rd, src_data, src_valid,
    input  req_ready, stall, wb_valid, wb_data, wb_rd, sel_err, timeout_err
  );
  modport slave (
    input  req_valid, req_sel, req_rd, src_data, src_valid,
    output req_ready, stall, wb_valid, wb_data, wb_rd, sel_err, timeout_err
  );
`else
  modport master (
    output req_valid, req_sel, req_rd, src_data, src_valid,
    input  req_ready, stall, wb_valid, wb_data, wb_rd, sel_err
  );
  modport slave (
    input  req_valid, req_sel, req_rd, src_data, src_valid,
    output req_ready, stall, wb_valid, wb_data, wb_rd, sel_err
  );
`endif

endinterface

// File: rtl/wb_src_select.sv
// rtl/wb_src_select.sv - combinational pick of one source word/valid from the packed bus
module wb_src_select #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [DATA_W-1:0]         data,
  output logic                      valid,
  output logic                      in_range
);

  // An index with no matching source leaves everything at zero.
  always_comb begin
    data     = '0;
    valid    = 1'b0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        data     = src_data[i*DATA_W +: DATA_W];
        valid    = src_valid[i];
        in_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/writeback_mux_seq.sv
// rtl/writeback_mux_seq.sv - registered writeback source mux that stalls on slow sources
// Optional WB_TIMEOUT_EN aborts a WAIT after TIMEOUT_CYC cycles with timeout_err.
module writeback_mux_seq
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int NUM_SRC     = 4,
  parameter int RD_W        = WB_RD_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  writeback_mux_seq_if.slave bus
);
  localparam int SEL_W = sel_width(NUM_SRC);

  wb_state_t         state;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_mux;
  logic [RD_W-1:0]   rd_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [DATA_W-1:0] pick_data;
  logic              pick_valid;
  logic              pick_in_range;
  logic              wb_valid_q;
  logic              sel_err_q;
  logic              ready;

  assign ready   = (state != ST_WAIT);
  // While waiting only the latched source matters; otherwise look at the incoming request.
  assign sel_mux = (state == ST_WAIT) ? sel_q : bus.req_sel;

  wb_src_select #(
    .DATA_W  (DATA_W),
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_src_select (
    .sel      (sel_mux),
    .src_data (bus.src_data),
    .src_valid(bus.src_valid),
    .data     (pick_data),
    .valid    (pick_valid),
    .in_range (pick_in_range)
  );

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             tmo_err_q;
  logic             tmo_hit;

  // cnt_q counts completed WAIT cycles, so this is the last allowed one.
  assign tmo_hit         = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign bus.timeout_err = tmo_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel_q      <= '0;
      rd_q       <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      wb_valid_q <= 1'b0;
      sel_err_q  <= 1'b0;
`ifdef WB_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_err_q  <= 1'b0;
`endif
    end else begin
      wb_valid_q <= 1'b0;
      sel_err_q  <= 1'b0;
`ifdef WB_TIMEOUT_EN
      tmo_err_q  <= 1'b0;
`endif
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (bus.req_valid) begin
            sel_q <= bus.req_sel;
            rd_q  <= bus.req_rd;
            if (!pick_in_range) begin
              state      <= ST_DONE;
              wb_valid_q <= 1'b1;
              sel_err_q  <= 1'b1;
              wb_data_q  <= '0;
              wb_rd_q    <= bus.req_rd;
            end else if (pick_valid) begin
              state      <= ST_DONE;
              wb_valid_q <= 1'b1;
              wb_data_q  <= pick_data;
              wb_rd_q    <= bus.req_rd;
            end else begin
              state <= ST_WAIT;
`ifdef WB_TIMEOUT_EN
              cnt_q <= '0;
`endif
            end
          end
        end
        ST_WAIT: begin
`ifdef WB_TIMEOUT_EN
          cnt_q <= cnt_q + 1'b1;
`endif
          if (pick_valid) begin
            state      <= ST_DONE;
            wb_valid_q <= 1'b1;
            wb_data_q  <= pick_data;
            wb_rd_q    <= rd_q;
`ifdef WB_TIMEOUT_EN
          end else if (tmo_hit) begin
            state      <= ST_DONE;
            wb_valid_q <= 1'b1;
            tmo_err_q  <= 1'b1;
            wb_data_q  <= '0;
            wb_rd_q    <= rd_q;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.stall     = (state == ST_WAIT);
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_writeback_mux_seq.sv
// tb/tb_writeback_mux_seq.sv - directed scoreboard bench for writeback_mux_seq (WB_TIMEOUT_EN aware)
module tb_writeback_mux_seq;

  logic clk;
  logic rst_n;

  writeback_mux_seq_if #(.DATA_W(32), .NUM_SRC(4), .RD_W(4)) bus ();
  writeback_mux_seq_if #(.DATA_W(32), .NUM_SRC(3), .RD_W(4)) bus3 ();

  writeback_mux_seq #(.DATA_W(32), .NUM_SRC(4), .RD_W(4), .TIMEOUT_CYC(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  writeback_mux_seq #(.DATA_W(32), .NUM_SRC(3), .RD_W(4), .TIMEOUT_CYC(10)) dut3 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  rd;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] rd, input logic err, input logic tmo);
    exp_t e;
    e.data = d; e.rd = rd; e.err = err; e.tmo = tmo;
    sb.push_back(e);
  endtask

  // Advance one clock, then score any writeback beat from the main DUT.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", 32'(bus.wb_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_data", bus.wb_data, e.data);
        chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
        chk("wb_sel_err", 32'(bus.sel_err), 32'(e.err));
`ifdef WB_TIMEOUT_EN
        chk("wb_timeout_err", 32'(bus.timeout_err), 32'(e.tmo));
`endif
      end
    end
  endtask

  initial begin
    int n;
    int guard;

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_sel    = '0;
    bus.req_rd     = '0;
    bus.src_data   = '0;
    bus.src_valid  = 4'b0001;
    bus3.req_valid = 1'b0;
    bus3.req_sel   = '0;
    bus3.req_rd    = '0;
    bus3.src_data  = '0;
    bus3.src_valid = 3'b001;
    #1;
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("rst_sel_err", 32'(bus.sel_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // ALU request, one-cycle latency
    bus.src_data[0 +: 32] = 32'h1234_5678;
    bus.req_sel   = 2'd0;
    bus.req_rd    = 4'd5;
    bus.req_valid = 1'b1;
    push(32'h1234_5678, 4'd5, 1'b0, 1'b0);
    tick();
    chk("alu_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("alu_stall", 32'(bus.stall), 32'd0);
    bus.req_valid = 1'b0;
    tick();
    chk("alu_wb_valid_drop", 32'(bus.wb_valid), 32'd0);

    // HD request, data 6 cycles later; RAM valid in between must be ignored
    bus.req_sel   = 2'd3;
    bus.req_rd    = 4'd9;
    bus.req_valid = 1'b1;
    push(32'hDEAD_BEEF, 4'd9, 1'b0, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      chk("hd_stall", 32'(bus.stall), 32'd1);
      chk("hd_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hd_wb_valid", 32'(bus.wb_valid), 32'd0);
      if (bus.stall === 1'b1) n++;
      if (k == 2) bus.src_valid[1] = 1'b1;
      if (k == 5) begin
        bus.src_valid[3]       = 1'b1;
        bus.src_data[96 +: 32] = 32'hDEAD_BEEF;
      end
      tick();
    end
    chk("hd_stall_cycles", 32'(n), 32'd6);
    chk("hd_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("hd_stall_done", 32'(bus.stall), 32'd0);
    bus.src_valid = 4'b0001;
    tick();

    // Back-to-back ALU requests
    for (int i = 1; i <= 4; i++) begin
      bus.req_sel          = 2'd0;
      bus.req_rd           = 4'(i);
      bus.src_data[0 +: 32] = 32'hA0 + 32'(i);
      bus.req_valid        = 1'b1;
      push(32'hA0 + 32'(i), 4'(i), 1'b0, 1'b0);
      tick();
      chk("b2b_wb_valid", 32'(bus.wb_valid), 32'd1);
    end
    bus.req_valid = 1'b0;
    tick();
    chk("b2b_idle_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("b2b_hold_wb_data", bus.wb_data, 32'hA4);
    chk("b2b_hold_wb_rd", 32'(bus.wb_rd), 32'd4);

    // Three-source instance: in-range then out-of-range back-to-back
    bus3.src_data[64 +: 32] = 32'h55;
    bus3.src_valid[2]       = 1'b1;
    bus3.req_sel            = 2'd2;
    bus3.req_rd             = 4'd2;
    bus3.req_valid          = 1'b1;
    tick();
    chk("n3_inrange_wb_valid", 32'(bus3.wb_valid), 32'd1);
    chk("n3_inrange_wb_data", bus3.wb_data, 32'h55);
    chk("n3_inrange_sel_err", 32'(bus3.sel_err), 32'd0);
    bus3.req_sel = 2'd3;
    bus3.req_rd  = 4'd7;
    tick();
    chk("oor_wb_valid", 32'(bus3.wb_valid), 32'd1);
    chk("oor_sel_err", 32'(bus3.sel_err), 32'd1);
    chk("oor_wb_data", bus3.wb_data, 32'd0);
    chk("oor_wb_rd", 32'(bus3.wb_rd), 32'd7);
    chk("oor_stall", 32'(bus3.stall), 32'd0);
    bus3.req_valid = 1'b0;
    tick();
    chk("oor_sel_err_drop", 32'(bus3.sel_err), 32'd0);
    chk("oor_wb_valid_drop", 32'(bus3.wb_valid), 32'd0);

    // Reset in the middle of a RAM wait discards the request
    bus.src_valid[1] = 1'b0;
    bus.req_sel      = 2'd1;
    bus.req_rd       = 4'd3;
    bus.req_valid    = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("mid_stall_a", 32'(bus.stall), 32'd1);
    tick();
    chk("mid_stall_b", 32'(bus.stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(bus.stall), 32'd0);
    chk("mid_rst_wb_data", bus.wb_data, 32'd0);
    chk("mid_rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    bus.src_valid[1]       = 1'b1;
    bus.src_data[32 +: 32] = 32'hBAD0_0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_no_wb_valid", 32'(bus.wb_valid), 32'd0);
    end
    bus.src_valid = 4'b0001;
    tick();

`ifdef WB_TIMEOUT_EN
    // RAM never answers: abort after 10 WAIT cycles
    bus.req_sel   = 2'd1;
    bus.req_rd    = 4'd6;
    bus.req_valid = 1'b1;
    push(32'd0, 4'd6, 1'b0, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    n     = 0;
    guard = 0;
    while (bus.wb_valid !== 1'b1 && guard < 50) begin
      if (bus.stall === 1'b1) n++;
      tick();
      guard++;
    end
    chk("tmo_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("tmo_wait_cycles", 32'(n), 32'd10);
    tick();

    // Valid on the limit cycle wins over the timeout
    bus.req_sel   = 2'd1;
    bus.req_rd    = 4'd8;
    bus.req_valid = 1'b1;
    push(32'h77, 4'd8, 1'b0, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("lim_stall", 32'(bus.stall), 32'd1);
      if (k == 9) begin
        bus.src_valid[1]       = 1'b1;
        bus.src_data[32 +: 32] = 32'h77;
      end
      tick();
    end
    chk("lim_wb_valid", 32'(bus.wb_valid), 32'd1);
`else
    // Without the timeout a wait simply persists
    bus.req_sel   = 2'd1;
    bus.req_rd    = 4'd6;
    bus.req_valid = 1'b1;
    push(32'h66, 4'd6, 1'b0, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      chk("long_stall", 32'(bus.stall), 32'd1);
      if (k == 29) begin
        bus.src_valid[1]       = 1'b1;
        bus.src_data[32 +: 32] = 32'h66;
      end
      tick();
    end
    chk("long_wb_valid", 32'(bus.wb_valid), 32'd1);
`endif
    bus.src_valid = 4'b0001;
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
